// File: rtl/layer_addr_gen.sv
// Per-layer convolution address sequencer: walks group/pixel/channel/tap loops,
// issues IFM read addresses over valid/ready and pulses the OFM write address per pixel.
module layer_addr_gen #(
   parameter int unsigned OFM_RAM_SIZE = 2378675,
   parameter int unsigned PE_COLS      = 16,
   parameter int unsigned ADDR_W       = $clog2(OFM_RAM_SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_layer,
   input  logic [8:0]        ifm_size,
   input  logic [10:0]       ifm_channel,
   input  logic [1:0]        kernel_size,
   input  logic [10:0]       num_filter,
   input  logic [ADDR_W-1:0] start_read_addr,
   input  logic [ADDR_W-1:0] start_write_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              pix_done,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [4:0]        grp_filters,
   output logic              busy,
   output logic              cfg_err,
   output logic              done_layer
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [10:0]       PE_N    = 11'(PE_COLS);
   localparam logic [ADDR_W-1:0] ADDR_1  = ADDR_W'(1);

   state_t r_state, w_state_nxt;
   logic   w_rd_valid, w_busy, w_done;

   // latched layer configuration and derived constants
   logic [8:0]        r_s;
   logic [1:0]        r_k;
   logic [10:0]       r_ch;
   logic [8:0]        r_ofm;
   logic [ADDR_W-1:0] r_plane;
   logic [ADDR_W-1:0] r_grp_stride;
   logic [ADDR_W-1:0] r_rbase;

   // loop counters; r_rem is the filter count still to be covered by this and later groups
   logic [1:0]        r_kx, r_ky;
   logic [10:0]       r_c;
   logic [8:0]        r_x, r_y;
   logic [10:0]       r_rem;

   // running address offsets, one per loop level
   logic [ADDR_W-1:0] r_row_start, r_pix_base, r_ch_base, r_row_base, r_addr;
   logic [ADDR_W-1:0] r_wr_grp, r_wr_cur;

   logic              r_pix_done;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [4:0]        r_grp_filters;
   logic              r_cfg_err;

   logic [8:0]        w_k9, w_ofm;
   logic [17:0]       w_ofm_sq, w_plane;
   logic [ADDR_W-1:0] w_grp_stride;
   logic              w_cfg_bad;

   logic              w_acc;
   logic              w_kx_end, w_ky_end, w_c_end, w_x_end, w_y_end, w_g_end;
   logic              w_pix_end, w_last;
   logic [ADDR_W-1:0] w_s_ext, w_pix_nxt, w_ch_nxt, w_row_nxt, w_line_nxt, w_grp_nxt;

   // configuration decode, only consumed during LOAD
   assign w_k9         = {7'd0, kernel_size};
   assign w_cfg_bad    = ((kernel_size != 2'd1) && (kernel_size != 2'd3)) ||
                         (ifm_size < w_k9) || (ifm_channel == '0) || (num_filter == '0);
   assign w_ofm        = ifm_size - w_k9 + 9'd1;
   assign w_ofm_sq     = 18'(w_ofm) * 18'(w_ofm);
   assign w_plane      = 18'(ifm_size) * 18'(ifm_size);
   assign w_grp_stride = ADDR_W'(PE_COLS) * ADDR_W'(w_ofm_sq);

   assign w_acc     = (r_state == RUN) && rd_ready;
   assign w_kx_end  = (r_kx == r_k - 2'd1);
   assign w_ky_end  = (r_ky == r_k - 2'd1);
   assign w_c_end   = (r_c == r_ch - 11'd1);
   assign w_x_end   = (r_x == r_ofm - 9'd1);
   assign w_y_end   = (r_y == r_ofm - 9'd1);
   assign w_g_end   = (r_rem <= PE_N);
   assign w_pix_end = w_acc && w_kx_end && w_ky_end && w_c_end;
   assign w_last    = w_pix_end && w_x_end && w_y_end && w_g_end;

   assign w_s_ext    = ADDR_W'(r_s);
   assign w_pix_nxt  = r_pix_base + ADDR_1;
   assign w_ch_nxt   = r_ch_base + r_plane;
   assign w_row_nxt  = r_row_base + w_s_ext;
   assign w_line_nxt = r_row_start + w_s_ext;
   assign w_grp_nxt  = r_wr_grp + r_grp_stride;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_valid  = 1'b0;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (start_layer) w_state_nxt = LOAD;
         end
         LOAD: w_state_nxt = w_cfg_bad ? DONE : RUN;
         RUN: begin
            w_rd_valid = 1'b1;
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s           <= '0;
         r_k           <= '0;
         r_ch          <= '0;
         r_ofm         <= '0;
         r_plane       <= '0;
         r_grp_stride  <= '0;
         r_rbase       <= '0;
         r_kx          <= '0;
         r_ky          <= '0;
         r_c           <= '0;
         r_x           <= '0;
         r_y           <= '0;
         r_rem         <= '0;
         r_row_start   <= '0;
         r_pix_base    <= '0;
         r_ch_base     <= '0;
         r_row_base    <= '0;
         r_addr        <= '0;
         r_wr_grp      <= '0;
         r_wr_cur      <= '0;
         r_pix_done    <= 1'b0;
         r_wr_addr     <= '0;
         r_grp_filters <= '0;
         r_cfg_err     <= 1'b0;
      end else begin
         r_pix_done <= 1'b0;
         if (r_state == LOAD) begin
            r_s          <= ifm_size;
            r_k          <= kernel_size;
            r_ch         <= ifm_channel;
            r_ofm        <= w_ofm;
            r_plane      <= ADDR_W'(w_plane);
            r_grp_stride <= w_grp_stride;
            r_rbase      <= start_read_addr;
            r_rem        <= num_filter;
            r_kx         <= '0;
            r_ky         <= '0;
            r_c          <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_row_start  <= start_read_addr;
            r_pix_base   <= start_read_addr;
            r_ch_base    <= start_read_addr;
            r_row_base   <= start_read_addr;
            r_addr       <= start_read_addr;
            r_wr_grp     <= start_write_addr;
            r_wr_cur     <= start_write_addr;
            r_cfg_err    <= w_cfg_bad;
         end else if (w_acc) begin
            // each loop level reloads every inner offset from its own advanced base
            if (!w_kx_end) begin
               r_kx   <= r_kx + 2'd1;
               r_addr <= r_addr + ADDR_1;
            end else begin
               r_kx <= '0;
               if (!w_ky_end) begin
                  r_ky       <= r_ky + 2'd1;
                  r_row_base <= w_row_nxt;
                  r_addr     <= w_row_nxt;
               end else begin
                  r_ky <= '0;
                  if (!w_c_end) begin
                     r_c        <= r_c + 11'd1;
                     r_ch_base  <= w_ch_nxt;
                     r_row_base <= w_ch_nxt;
                     r_addr     <= w_ch_nxt;
                  end else begin
                     r_c           <= '0;
                     r_pix_done    <= 1'b1;
                     r_wr_addr     <= r_wr_cur;
                     r_grp_filters <= w_g_end ? 5'(r_rem) : 5'(PE_COLS);
                     if (!w_x_end) begin
                        r_x        <= r_x + 9'd1;
                        r_wr_cur   <= r_wr_cur + ADDR_1;
                        r_pix_base <= w_pix_nxt;
                        r_ch_base  <= w_pix_nxt;
                        r_row_base <= w_pix_nxt;
                        r_addr     <= w_pix_nxt;
                     end else begin
                        r_x <= '0;
                        if (!w_y_end) begin
                           r_y         <= r_y + 9'd1;
                           r_wr_cur    <= r_wr_cur + ADDR_1;
                           r_row_start <= w_line_nxt;
                           r_pix_base  <= w_line_nxt;
                           r_ch_base   <= w_line_nxt;
                           r_row_base  <= w_line_nxt;
                           r_addr      <= w_line_nxt;
                        end else begin
                           r_y         <= '0;
                           r_rem       <= r_rem - PE_N;
                           r_wr_grp    <= w_grp_nxt;
                           r_wr_cur    <= w_grp_nxt;
                           r_row_start <= r_rbase;
                           r_pix_base  <= r_rbase;
                           r_ch_base   <= r_rbase;
                           r_row_base  <= r_rbase;
                           r_addr      <= r_rbase;
                        end
                     end
                  end
               end
            end
         end
      end
   end

   assign rd_addr     = r_addr;
   assign rd_valid    = w_rd_valid;
   assign pix_done    = r_pix_done;
   assign wr_addr     = r_wr_addr;
   assign grp_filters = r_grp_filters;
   assign busy        = w_busy;
   assign cfg_err     = r_cfg_err;
   assign done_layer  = w_done;

endmodule

// File: tb/tb_layer_addr_gen.sv
// Randomised bench for layer_addr_gen against a nested-loop address model.
module tb_layer_addr_gen;

   localparam int unsigned AW = 22;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_layer = 1'b0;
   logic [8:0]    ifm_size = '0;
   logic [10:0]   ifm_channel = '0;
   logic [1:0]    kernel_size = '0;
   logic [10:0]   num_filter = '0;
   logic [AW-1:0] start_read_addr = '0;
   logic [AW-1:0] start_write_addr = '0;
   logic          rd_ready = 1'b1;
   logic [AW-1:0] rd_addr;
   logic          rd_valid;
   logic          pix_done;
   logic [AW-1:0] wr_addr;
   logic [4:0]    grp_filters;
   logic          busy;
   logic          cfg_err;
   logic          done_layer;

   layer_addr_gen #(.OFM_RAM_SIZE(2378675), .PE_COLS(16)) dut (
      .clk(clk), .rst(rst), .start_layer(start_layer),
      .ifm_size(ifm_size), .ifm_channel(ifm_channel), .kernel_size(kernel_size),
      .num_filter(num_filter), .start_read_addr(start_read_addr),
      .start_write_addr(start_write_addr), .rd_addr(rd_addr), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .pix_done(pix_done), .wr_addr(wr_addr),
      .grp_filters(grp_filters), .busy(busy), .cfg_err(cfg_err), .done_layer(done_layer)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [AW-1:0] exp_rd[$];
   logic [AW-1:0] exp_wr[$];
   int            exp_gf[$];
   int            tpp = 1;

   bit mon_on = 1'b0;
   bit ready_rand = 1'b0;
   int rd_idx = 0;
   int pix_idx = 0;
   int done_cnt = 0;
   bit prev_pix_end = 1'b0;
   bit prev_final = 1'b0;
   bit m_acc;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference: plain nested loops over the layer, outermost group first
   task automatic build_model(input int s, input int ch, input int k, input int nf,
                              input int unsigned r, input int unsigned w);
      int ofm, ng;
      ofm = s - k + 1;
      ng  = (nf + 15) / 16;
      exp_rd.delete();
      exp_wr.delete();
      exp_gf.delete();
      tpp = ch * k * k;
      for (int g = 0; g < ng; g++)
         for (int y = 0; y < ofm; y++)
            for (int x = 0; x < ofm; x++) begin
               for (int c = 0; c < ch; c++)
                  for (int ky = 0; ky < k; ky++)
                     for (int kx = 0; kx < k; kx++)
                        exp_rd.push_back(AW'(r + c*s*s + (y+ky)*s + x + kx));
               exp_wr.push_back(AW'(w + g*16*ofm*ofm + y*ofm + x));
               exp_gf.push_back((nf - g*16) < 16 ? (nf - g*16) : 16);
            end
   endtask

   always @(negedge clk) begin
      if (!mon_on) begin
         rd_idx = 0;
         pix_idx = 0;
         done_cnt = 0;
         prev_pix_end = 1'b0;
         prev_final = 1'b0;
      end else begin
         if (rd_valid) begin
            if (rd_idx < exp_rd.size()) chk("rd_addr", rd_addr, exp_rd[rd_idx]);
            else chk("rd_extra", rd_idx, exp_rd.size());
         end
         chk("pix_done", pix_done, prev_pix_end);
         chk("done_layer", done_layer, prev_final);
         if (pix_done) begin
            if (pix_idx < exp_wr.size()) begin
               chk("wr_addr", wr_addr, exp_wr[pix_idx]);
               chk("grp_filters", grp_filters, exp_gf[pix_idx]);
            end else chk("pix_extra", pix_idx, exp_wr.size());
            pix_idx++;
         end
         if (done_layer) done_cnt++;
         m_acc = rd_valid && rd_ready;
         prev_pix_end = m_acc && (((rd_idx + 1) % tpp) == 0);
         prev_final = m_acc && ((rd_idx + 1) == exp_rd.size());
         if (m_acc) rd_idx++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rd_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic set_cfg(input int s, input int ch, input int k, input int nf,
                          input int unsigned r, input int unsigned w);
      ifm_size = 9'(s);
      ifm_channel = 11'(ch);
      kernel_size = 2'(k);
      num_filter = 11'(nf);
      start_read_addr = AW'(r);
      start_write_addr = AW'(w);
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start_layer = 1'b1;
      @(posedge clk);
      #1 start_layer = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_rd_valid"}, rd_valid, 0);
      chk({tag, "_pix_done"}, pix_done, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_grp_filters"}, grp_filters, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cfg_err"}, cfg_err, 0);
      chk({tag, "_done_layer"}, done_layer, 0);
   endtask

   // mode 0: plain run; 1: extra start_layer plus config change mid-RUN; 2: start_layer during DONE
   task automatic run_legal(input int s, input int ch, input int k, input int nf,
                            input int unsigned r, input int unsigned w, input bit rr, input int mode);
      int cyc;
      bit fired;
      build_model(s, ch, k, nf, r, w);
      ready_rand = rr;
      set_cfg(s, ch, k, nf, r, w);
      pulse_start();
      mon_on = 1'b1;
      @(negedge clk);
      chk("load_busy", busy, 1);
      chk("load_rd_valid", rd_valid, 0);
      @(negedge clk);
      chk("first_rd_valid", rd_valid, 1);
      chk("cfg_err_clear", cfg_err, 0);
      cyc = 0;
      fired = 1'b0;
      while (done_cnt == 0 && cyc < 20000) begin
         @(posedge clk);
         cyc++;
         if (mode == 1 && !fired && rd_idx >= 30) begin
            fired = 1'b1;
            #1;
            set_cfg(5, 1, 1, 3, 7, 9);
            start_layer = 1'b1;
            @(posedge clk);
            #1 start_layer = 1'b0;
         end else if (mode == 2 && !fired && prev_final) begin
            fired = 1'b1;
            #1 start_layer = 1'b1;
            @(posedge clk);
            #1 start_layer = 1'b0;
         end
      end
      if (cyc >= 20000) chk("done_timeout", cyc, -1);
      repeat (3) @(posedge clk);
      chk("total_reads", rd_idx, exp_rd.size());
      chk("total_pix", pix_idx, exp_wr.size());
      chk("done_count", done_cnt, 1);
      chk("idle_busy", busy, 0);
      mon_on = 1'b0;
      @(posedge clk);
   endtask

   task automatic run_illegal(input int s, input int ch, input int k, input int nf);
      ready_rand = 1'b0;
      set_cfg(s, ch, k, nf, 100, 5000);
      pulse_start();
      @(negedge clk);
      chk("bad_t1_done", done_layer, 0);
      chk("bad_t1_busy", busy, 1);
      chk("bad_t1_rd_valid", rd_valid, 0);
      @(negedge clk);
      chk("bad_t2_done", done_layer, 1);
      chk("bad_t2_cfg_err", cfg_err, 1);
      chk("bad_t2_rd_valid", rd_valid, 0);
      @(negedge clk);
      chk("bad_t3_done", done_layer, 0);
      chk("bad_t3_busy", busy, 0);
      chk("bad_t3_cfg_err", cfg_err, 1);
   endtask

   initial begin
      int unsigned pin[10];
      int s, ch, k, nf, cyc;
      pin = '{100, 101, 102, 104, 105, 106, 108, 109, 110, 116};

      #1 chk_zero("reset");
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      build_model(4, 2, 3, 20, 100, 5000);
      for (int i = 0; i < 10; i++) chk("model_pin_rd", exp_rd[i], pin[i]);
      chk("model_pin_reads", exp_rd.size(), 144);
      chk("model_pin_pix", exp_wr.size(), 8);
      chk("model_pin_wr_g1", exp_wr[4], 5064);
      chk("model_pin_gf_g1", exp_gf[4], 4);
      chk("model_pin_gf_g0", exp_gf[0], 16);

      run_legal(4, 2, 3, 20, 100, 5000, 1'b0, 0);
      run_legal(4, 2, 3, 20, 100, 5000, 1'b1, 0);
      run_legal(3, 1, 1, 16, 100, 5000, 1'b0, 0);

      run_illegal(4, 2, 2, 20);
      run_illegal(2, 2, 3, 20);
      run_illegal(4, 2, 3, 0);
      run_illegal(4, 0, 3, 20);
      run_legal(3, 1, 1, 16, 100, 5000, 1'b0, 0);

      run_legal(4, 2, 3, 20, 100, 5000, 1'b1, 1);
      run_legal(4, 2, 3, 20, 100, 5000, 1'b1, 2);

      for (int n = 0; n < 6; n++) begin
         k  = ($urandom_range(0, 1) == 1) ? 3 : 1;
         s  = $urandom_range(k, 6);
         ch = $urandom_range(1, 3);
         nf = $urandom_range(1, 40);
         run_legal(s, ch, k, nf, $urandom_range(0, 32'h3FFFFF), $urandom_range(0, 32'h3FFFFF),
                   1'b1, 0);
      end

      ready_rand = 1'b0;
      build_model(4, 2, 3, 20, 100, 5000);
      set_cfg(4, 2, 3, 20, 100, 5000);
      pulse_start();
      mon_on = 1'b1;
      cyc = 0;
      while (rd_idx < 50 && cyc < 1000) begin
         @(posedge clk);
         cyc++;
      end
      chk("abort_reached_50", rd_idx, 50);
      mon_on = 1'b0;
      #1 rst = 1'b1;
      #1 chk_zero("abort");
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_no_done", done_layer, 0);
         chk("abort_idle", busy, 0);
      end
      run_legal(4, 2, 3, 20, 100, 5000, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
